branch_update_unit: RTL and testbench

BRANCH_UPDATE_UNIT -- requirements
Module: branch_update_unit

---
 rtl/branch_update_unit.sv | 107 ++++++++++
 tb/tb_branch_update_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_unit.sv
// Branch resolve/update: 1-cycle mispredict redirect, DEPTH-entry queue to predictor (>=2 cycles to PB_BUS).
// bu_ready drops when the queue is full; pb_hold stalls draining. Optional counters: BU_PERF_CNT_EN.
module branch_update_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        E_valid,
    input  logic [31:0] E_pc,
    input  logic [31:0] E_inst,
    input  logic        E_direct_jump,
    input  logic        E_indirect_jump,
    input  logic        E_br_taken,
    input  logic [31:0] E_br_target,
    input  logic        E_pred_taken,
    input  logic [31:0] E_pred_target,
    input  logic        flush,
    input  logic        pb_hold,
    output logic        bu_ready,
    output logic        predict_error,
    output logic [31:0] redirect_pc,
    output logic [98:0] PB_BUS
`ifdef BU_PERF_CNT_EN
    ,
    output logic [31:0] br_cnt,
    output logic [31:0] mispred_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [98:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_is_br;
    logic          w_enq;
    logic          w_deq;
    logic          w_mispred;
    logic [98:0]   w_entry;

    assign bu_ready  = (r_count < FULL_CNT);
    assign w_accept  = E_valid && bu_ready && !flush;
    assign w_is_br   = E_direct_jump || E_indirect_jump;
    assign w_enq     = w_accept && w_is_br;
    assign w_deq     = (r_count != '0) && !pb_hold;

    // Conditional branches train direction only; their target comes from decode, so it is not compared.
    assign w_mispred = E_direct_jump
                     ? ((E_pred_taken != E_br_taken) || (E_br_taken && (E_pred_target != E_br_target)))
                     : (E_pred_taken != E_br_taken);

    assign w_entry = {E_inst, E_direct_jump, E_indirect_jump, E_br_taken, E_br_target, E_pc};

    always_ff @(posedge clk) begin
        if (rstn && w_enq) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            predict_error <= 1'b0;
            redirect_pc   <= '0;
            PB_BUS        <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + AW'(1);
            if (w_deq) r_rptr <= r_rptr + AW'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // All-zero when idle so the jump flags double as update strobes.
            PB_BUS        <= w_deq ? r_mem[r_rptr] : '0;
            predict_error <= w_enq && w_mispred;
            if (w_enq && w_mispred) begin
                redirect_pc <= E_br_taken ? E_br_target : (E_pc + 32'd4);
            end
        end
    end

`ifdef BU_PERF_CNT_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_enq)         r_br_cnt      <= r_br_cnt + 32'd1;
            if (predict_error) r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign br_cnt      = r_br_cnt;
    assign mispred_cnt = r_mispred_cnt;
`endif

endmodule

// File: tb/tb_branch_update_unit.sv
module tb_branch_update_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        E_valid;
    logic [31:0] E_pc;
    logic [31:0] E_inst;
    logic        E_direct_jump;
    logic        E_indirect_jump;
    logic        E_br_taken;
    logic [31:0] E_br_target;
    logic        E_pred_taken;
    logic [31:0] E_pred_target;
    logic        flush;
    logic        pb_hold;
    logic        bu_ready;
    logic        predict_error;
    logic [31:0] redirect_pc;
    logic [98:0] PB_BUS;
`ifdef BU_PERF_CNT_EN
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    branch_update_unit #(.DEPTH(4)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .E_valid         (E_valid),
        .E_pc            (E_pc),
        .E_inst          (E_inst),
        .E_direct_jump   (E_direct_jump),
        .E_indirect_jump (E_indirect_jump),
        .E_br_taken      (E_br_taken),
        .E_br_target     (E_br_target),
        .E_pred_taken    (E_pred_taken),
        .E_pred_target   (E_pred_target),
        .flush           (flush),
        .pb_hold         (pb_hold),
        .bu_ready        (bu_ready),
        .predict_error   (predict_error),
        .redirect_pc     (redirect_pc),
        .PB_BUS          (PB_BUS)
`ifdef BU_PERF_CNT_EN
        ,
        .br_cnt          (br_cnt),
        .mispred_cnt     (mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [98:0] obs, input logic [98:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [98:0] ent(input logic [31:0] inst, input logic dj, input logic ij,
                                        input logic bt, input logic [31:0] btgt, input logic [31:0] pc);
        return {inst, dj, ij, bt, btgt, pc};
    endfunction

    task automatic offer(input logic [31:0] pc, input logic [31:0] inst, input logic dj, input logic ij,
                         input logic bt, input logic [31:0] btgt, input logic pt, input logic [31:0] ptgt);
        E_valid = 1'b1; E_pc = pc; E_inst = inst; E_direct_jump = dj; E_indirect_jump = ij;
        E_br_taken = bt; E_br_target = btgt; E_pred_taken = pt; E_pred_target = ptgt;
    endtask

    task automatic idle();
        E_valid = 1'b0; E_direct_jump = 1'b0; E_indirect_jump = 1'b0;
        E_br_taken = 1'b0; E_pred_taken = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; pb_hold = 1'b0;
        E_pc = '0; E_inst = '0; E_br_target = '0; E_pred_target = '0;
        idle();
        tick(); tick();
        chk("rst_pe", predict_error, 0);
        chk("rst_redir", redirect_pc, 0);
        chk("rst_pb", PB_BUS, 0);
        chk("rst_rdy", bu_ready, 1);
        rstn = 1'b1;

        // direct b, wrong target
        offer(32'h1C000010, 32'h50000100, 1, 0, 1, 32'h1C000200, 1, 32'h1C000100);
        tick(); idle();
        chk("b_pe", predict_error, 1);
        chk("b_redir", redirect_pc, 32'h1C000200);
        tick();
        chk("b_pe_pulse", predict_error, 0);
        chk("b_redir_hold", redirect_pc, 32'h1C000200);
        chk("b_pb", PB_BUS, ent(32'h50000100, 1, 0, 1, 32'h1C000200, 32'h1C000010));
        tick();
        chk("b_pb_clear", PB_BUS, 0);

        // beq predicted taken, actually not taken
        offer(32'h1C000020, 32'h58000010, 0, 1, 0, 32'h1C000040, 1, 32'h1C000040);
        tick(); idle();
        chk("beq_pe", predict_error, 1);
        chk("beq_redir", redirect_pc, 32'h1C000024);
        chk("beq_pb_early", PB_BUS, 0);
        tick();
        chk("beq_pe_pulse", predict_error, 0);
        chk("beq_pb_ij", PB_BUS[65], 1);
        chk("beq_pb_bt", PB_BUS[64], 0);
        chk("beq_pb", PB_BUS, ent(32'h58000010, 0, 1, 0, 32'h1C000040, 32'h1C000020));
        tick();
        chk("beq_pb_clear", PB_BUS, 0);

        // beq correct direction, target mismatch ignored
        offer(32'h1C000030, 32'h58000050, 0, 1, 1, 32'h1C000080, 1, 32'h0);
        tick(); idle();
        chk("beq2_pe", predict_error, 0);
        chk("beq2_redir_hold", redirect_pc, 32'h1C000024);
        tick();
        chk("beq2_pb", PB_BUS, ent(32'h58000050, 0, 1, 1, 32'h1C000080, 32'h1C000030));
        tick();
        chk("beq2_pb_clear", PB_BUS, 0);

        // non-branch with mismatching predictions is ignored
        offer(32'h1C000040, 32'h02800000, 0, 0, 1, 32'h1C000300, 0, 32'h0);
        tick(); idle();
        chk("nb_pe", predict_error, 0);
        tick();
        chk("nb_pb", PB_BUS, 0);

        // fill under hold, then drain in order
        pb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(32'h100 + 32'(i*4), 32'hA0 + 32'(i), 0, 1, 0, 32'h0, 0, 32'h0);
            tick();
            chk("fill_rdy", bu_ready, (i < 3) ? 1 : 0);
            chk("fill_pb", PB_BUS, 0);
        end
        offer(32'h110, 32'hA4, 0, 1, 0, 32'h0, 0, 32'h0);
        tick(); idle();
        chk("full_rdy", bu_ready, 0);
        pb_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_pb", PB_BUS, ent(32'hA0 + 32'(i), 0, 1, 0, 32'h0, 32'h100 + 32'(i*4)));
        end
        tick();
        chk("drain_done", PB_BUS, 0);
        chk("drain_rdy", bu_ready, 1);

        // enqueue at count==DEPTH-1 together with a dequeue
        pb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(32'h200 + 32'(i*4), 32'hB0 + 32'(i), 0, 1, 1, 32'h300, 1, 32'h0);
            tick();
        end
        pb_hold = 1'b0;
        offer(32'h20C, 32'hB3, 0, 1, 1, 32'h300, 1, 32'h0);
        tick(); idle();
        chk("sim_pb0", PB_BUS, ent(32'hB0, 0, 1, 1, 32'h300, 32'h200));
        chk("sim_rdy", bu_ready, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("sim_pb", PB_BUS, ent(32'hB0 + 32'(i), 0, 1, 1, 32'h300, 32'h200 + 32'(i*4)));
        end
        tick();
        chk("sim_done", PB_BUS, 0);

        // flush blocks a mispredicting branch; queued entry still drains
        pb_hold = 1'b1;
        offer(32'h400, 32'hC0, 1, 0, 1, 32'h500, 1, 32'h500);
        tick();
        flush = 1'b1;
        offer(32'h404, 32'hC1, 1, 0, 1, 32'h600, 0, 32'h0);
        tick(); idle();
        flush = 1'b0; pb_hold = 1'b0;
        chk("fl_pe", predict_error, 0);
        tick();
        chk("fl_pb", PB_BUS, ent(32'hC0, 1, 0, 1, 32'h500, 32'h400));
        chk("fl_pe2", predict_error, 0);
        tick();
        chk("fl_pb_none", PB_BUS, 0);

        // reset mid-operation with 3 queued and a pending mispredict
        pb_hold = 1'b1;
        offer(32'h700, 32'hD0, 0, 1, 0, 32'h0, 0, 32'h0); tick();
        offer(32'h704, 32'hD1, 0, 1, 0, 32'h0, 0, 32'h0); tick();
        offer(32'h708, 32'hD2, 0, 1, 1, 32'h800, 0, 32'h0); tick(); idle();
        chk("pre_rst_pe", predict_error, 1);
        chk("pre_rst_redir", redirect_pc, 32'h800);
        rstn = 1'b0; pb_hold = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mrst_pe", predict_error, 0);
        chk("mrst_pb", PB_BUS, 0);
        chk("mrst_redir", redirect_pc, 0);
        chk("mrst_rdy", bu_ready, 1);
`ifdef BU_PERF_CNT_EN
        chk("mrst_brcnt", br_cnt, 0);
        chk("mrst_mpcnt", mispred_cnt, 0);
`endif
        tick();
        chk("post_rst_pb", PB_BUS, 0);
        tick();
        chk("post_rst_pb2", PB_BUS, 0);
        chk("post_rst_rdy", bu_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
